// File: rtl/udatapath_pkg.sv
// udatapath_pkg: ALU opcodes, IR field positions and flag bit indices shared by the datapath.
package udatapath_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_PASSA = 4'd5;
  localparam logic [3:0] ALU_PASSB = 4'd6;
  localparam logic [3:0] ALU_SLL1 = 4'd7;
  localparam logic [3:0] ALU_SRL1 = 4'd8;
  localparam logic [3:0] ALU_SRA1 = 4'd9;
  localparam int IR_A_LSB = 14;
  localparam int IR_B_LSB = 0;
  localparam int IR_C_LSB = 25;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/udatapath_regfile.sv
// udatapath_regfile: register file with two read ports, writeback/external write mux and a clear port.
module udatapath_regfile
  import udatapath_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int REG_COUNT = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int IR_INDEX = 6
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [REG_ADDR_WIDTH-1:0] rdAddrA,
  input  logic [REG_ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATAWIDTH_BUS-1:0]  rdDataA,
  output logic [DATAWIDTH_BUS-1:0]  rdDataB,
  input  logic                      wbEn,
  input  logic [REG_ADDR_WIDTH-1:0] wbAddr,
  input  logic [DATAWIDTH_BUS-1:0]  wbData,
  input  logic                      extEn,
  input  logic [REG_ADDR_WIDTH-1:0] extAddr,
  input  logic [DATAWIDTH_BUS-1:0]  extData,
  input  logic                      clrEn,
  input  logic [REG_ADDR_WIDTH-1:0] clrAddr,
  output logic [DATAWIDTH_BUS-1:0]  irOut
);
  logic [DATAWIDTH_BUS-1:0] regs [REG_COUNT];
  logic wrEn;
  logic [REG_ADDR_WIDTH-1:0] wrAddr;
  logic [DATAWIDTH_BUS-1:0] wrData;
  always_comb begin
    wrEn = wbEn || extEn;
    wrAddr = wbEn ? wbAddr : extAddr;
    wrData = wbEn ? wbData : extData;
  end
  // register 0 is never written, so it stays at its reset value of zero; clear is last so it wins
  always_ff @(posedge clk)
    if (!rstN) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (wrEn && wrAddr != '0) regs[wrAddr] <= wrData;
      if (clrEn) regs[clrAddr] <= '0;
    end
  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];
  assign irOut = regs[IR_INDEX];
endmodule

// File: rtl/udatapath_pipe.sv
// udatapath_pipe: two-stage issue/execute datapath with forwarding, ALU, flags and register file.
module udatapath_pipe
  import udatapath_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int REG_COUNT = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int IR_INDEX = 6
) (
  input  logic                               uDATAPATH_CLOCK_50,
  input  logic                               uDATAPATH_RESET_InLow,
  input  logic                               uDATAPATH_issue_valid_InHigh,
  output logic                               uDATAPATH_issue_ready_OutHigh,
  input  logic                               uDATAPATH_stall_InHigh,
  input  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_addrA_InBUS,
  input  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_addrB_InBUS,
  input  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_addrC_InBUS,
  input  logic                               uDATAPATH_selA_InHigh,
  input  logic                               uDATAPATH_selB_InHigh,
  input  logic                               uDATAPATH_selC_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] uDATAPATH_aluselection_InBUS,
  input  logic                               uDATAPATH_wben_InHigh,
  input  logic                               uDATAPATH_flagload_InHigh,
  input  logic                               uDATAPATH_extwr_valid_InHigh,
  output logic                               uDATAPATH_extwr_ready_OutHigh,
  input  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_extwr_addr_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           uDATAPATH_extwr_data_InBUS,
  input  logic                               uDATAPATH_clear_valid_InHigh,
  input  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_clear_addr_InBUS,
  output logic [DATAWIDTH_BUS-1:0]           uDATAPATH_data_OutBUS,
  output logic                               uDATAPATH_result_valid_OutHigh,
  output logic                               uDATAPATH_overflow_OutLow,
  output logic                               uDATAPATH_carry_OutLow,
  output logic                               uDATAPATH_negative_OutLow,
  output logic                               uDATAPATH_zero_OutLow,
  output logic [DATAWIDTH_BUS-1:0]           uDATAPATH_Registro_IR,
  output logic [DATAWIDTH_BUS-1:0]           uDATAPATH_BUS_A,
  output logic [DATAWIDTH_BUS-1:0]           uDATAPATH_BUS_B
);
  localparam int MSB = DATAWIDTH_BUS - 1;
  logic stall, accept, wbEn, extEn;
  logic [REG_ADDR_WIDTH-1:0] idxA, idxB, idxC, s1Dest;
  logic [DATAWIDTH_BUS-1:0] rdA, rdB, opA, opB, aluOut, bEff;
  logic [DATAWIDTH_BUS:0] sum;
  logic [DATAWIDTH_ALU_SELECTION-1:0] s1Alu;
  logic s1Valid, s1Wben, s1Flagload, isSub, isArith, aluValid;
  logic [3:0] flags, aluFlags;
  assign stall = uDATAPATH_stall_InHigh;
  assign accept = uDATAPATH_issue_valid_InHigh && !stall;
  assign uDATAPATH_issue_ready_OutHigh = !stall;
  assign wbEn = s1Valid && s1Wben && !stall;
  assign uDATAPATH_extwr_ready_OutHigh = !wbEn;
  assign extEn = uDATAPATH_extwr_valid_InHigh && !wbEn;
  assign {uDATAPATH_overflow_OutLow, uDATAPATH_carry_OutLow, uDATAPATH_negative_OutLow, uDATAPATH_zero_OutLow} =
    ~{flags[FLAG_V], flags[FLAG_C], flags[FLAG_N], flags[FLAG_Z]};
  // operands bypass the register file when stage 1 is about to write the same non-zero index
  always_comb begin
    idxA = uDATAPATH_selA_InHigh ? uDATAPATH_Registro_IR[IR_A_LSB +: REG_ADDR_WIDTH] : uDATAPATH_addrA_InBUS;
    idxB = uDATAPATH_selB_InHigh ? uDATAPATH_Registro_IR[IR_B_LSB +: REG_ADDR_WIDTH] : uDATAPATH_addrB_InBUS;
    idxC = uDATAPATH_selC_InHigh ? uDATAPATH_Registro_IR[IR_C_LSB +: REG_ADDR_WIDTH] : uDATAPATH_addrC_InBUS;
    opA = (s1Valid && s1Wben && idxA == s1Dest && idxA != '0) ? aluOut : rdA;
    opB = (s1Valid && s1Wben && idxB == s1Dest && idxB != '0) ? aluOut : rdB;
  end
  always_comb begin
    isSub = s1Alu == ALU_SUB;
    isArith = isSub || s1Alu == ALU_ADD;
    bEff = isSub ? ~uDATAPATH_BUS_B : uDATAPATH_BUS_B;
    sum = {1'b0, uDATAPATH_BUS_A} + {1'b0, bEff} + {{DATAWIDTH_BUS{1'b0}}, isSub};
    aluOut = isArith ? sum[MSB:0] :
             s1Alu == ALU_AND ? uDATAPATH_BUS_A & uDATAPATH_BUS_B :
             s1Alu == ALU_OR ? uDATAPATH_BUS_A | uDATAPATH_BUS_B :
             s1Alu == ALU_XOR ? uDATAPATH_BUS_A ^ uDATAPATH_BUS_B :
             s1Alu == ALU_PASSA ? uDATAPATH_BUS_A :
             s1Alu == ALU_PASSB ? uDATAPATH_BUS_B :
             s1Alu == ALU_SLL1 ? uDATAPATH_BUS_A << 1 :
             s1Alu == ALU_SRL1 ? uDATAPATH_BUS_A >> 1 :
             s1Alu == ALU_SRA1 ? {uDATAPATH_BUS_A[MSB], uDATAPATH_BUS_A[MSB:1]} : '0;
    aluValid = s1Alu <= ALU_SRA1;
    aluFlags = '0;
    aluFlags[FLAG_V] = isArith && (uDATAPATH_BUS_A[MSB] == bEff[MSB]) && (sum[MSB] != uDATAPATH_BUS_A[MSB]);
    aluFlags[FLAG_C] = isArith && sum[DATAWIDTH_BUS];
    aluFlags[FLAG_N] = aluOut[MSB];
    aluFlags[FLAG_Z] = aluOut == '0;
  end
  always_ff @(posedge uDATAPATH_CLOCK_50)
    if (!uDATAPATH_RESET_InLow) begin
      s1Valid <= 1'b0;
      uDATAPATH_result_valid_OutHigh <= 1'b0;
      uDATAPATH_BUS_A <= '0;
      uDATAPATH_BUS_B <= '0;
      uDATAPATH_data_OutBUS <= '0;
      s1Dest <= '0;
      s1Alu <= '0;
      s1Wben <= 1'b0;
      s1Flagload <= 1'b0;
      flags <= '0;
    end else if (!stall) begin
      s1Valid <= accept;
      uDATAPATH_result_valid_OutHigh <= s1Valid;
      if (accept) begin
        uDATAPATH_BUS_A <= opA;
        uDATAPATH_BUS_B <= opB;
        s1Dest <= idxC;
        s1Alu <= uDATAPATH_aluselection_InBUS;
        s1Wben <= uDATAPATH_wben_InHigh;
        s1Flagload <= uDATAPATH_flagload_InHigh;
      end
      if (s1Valid) uDATAPATH_data_OutBUS <= aluOut;
      if (s1Valid && s1Flagload && aluValid) flags <= aluFlags;
    end
  udatapath_regfile #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS), .REG_COUNT(REG_COUNT),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .IR_INDEX(IR_INDEX)
  ) regfile (
    .clk(uDATAPATH_CLOCK_50), .rstN(uDATAPATH_RESET_InLow),
    .rdAddrA(idxA), .rdAddrB(idxB), .rdDataA(rdA), .rdDataB(rdB),
    .wbEn(wbEn), .wbAddr(s1Dest), .wbData(aluOut),
    .extEn(extEn), .extAddr(uDATAPATH_extwr_addr_InBUS), .extData(uDATAPATH_extwr_data_InBUS),
    .clrEn(uDATAPATH_clear_valid_InHigh), .clrAddr(uDATAPATH_clear_addr_InBUS),
    .irOut(uDATAPATH_Registro_IR)
  );
endmodule

// File: tb/tb_udatapath_pipe.sv
// tb_udatapath_pipe: directed bench with a result scoreboard for udatapath_pipe.
module tb_udatapath_pipe;
  import udatapath_pkg::*;
  logic clk = 0, rstN = 0, iv = 0, stall = 0, sA = 0, sB = 0, sC = 0, wbe = 0, fle = 0;
  logic exV = 0, clV = 0;
  logic [3:0] aA = 0, aB = 0, aC = 0, alu = 0, exA = 0, clA = 0;
  logic [31:0] exD = 0;
  logic ready, exReady, rv, ov, cy, ng, zr;
  logic [31:0] dout, ir, busA, busB;
  logic [31:0] sb[$];
  int nVec = 0, nErr = 0;
  logic [3:0] tOp[8] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_PASSB, ALU_SLL1, ALU_SRL1, ALU_SRA1, 4'd12};
  logic [3:0] tA[8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd10, 4'd10, 4'd1};
  logic [31:0] tE[8] = '{32'd5, 32'd7, 32'd2, 32'd7, 32'd10, 32'h40000000, 32'hC0000000, 32'd0};

  always #5 clk = ~clk;

  udatapath_pipe dut (
    .uDATAPATH_CLOCK_50(clk), .uDATAPATH_RESET_InLow(rstN),
    .uDATAPATH_issue_valid_InHigh(iv), .uDATAPATH_issue_ready_OutHigh(ready),
    .uDATAPATH_stall_InHigh(stall),
    .uDATAPATH_addrA_InBUS(aA), .uDATAPATH_addrB_InBUS(aB), .uDATAPATH_addrC_InBUS(aC),
    .uDATAPATH_selA_InHigh(sA), .uDATAPATH_selB_InHigh(sB), .uDATAPATH_selC_InHigh(sC),
    .uDATAPATH_aluselection_InBUS(alu), .uDATAPATH_wben_InHigh(wbe), .uDATAPATH_flagload_InHigh(fle),
    .uDATAPATH_extwr_valid_InHigh(exV), .uDATAPATH_extwr_ready_OutHigh(exReady),
    .uDATAPATH_extwr_addr_InBUS(exA), .uDATAPATH_extwr_data_InBUS(exD),
    .uDATAPATH_clear_valid_InHigh(clV), .uDATAPATH_clear_addr_InBUS(clA),
    .uDATAPATH_data_OutBUS(dout), .uDATAPATH_result_valid_OutHigh(rv),
    .uDATAPATH_overflow_OutLow(ov), .uDATAPATH_carry_OutLow(cy),
    .uDATAPATH_negative_OutLow(ng), .uDATAPATH_zero_OutLow(zr),
    .uDATAPATH_Registro_IR(ir), .uDATAPATH_BUS_A(busA), .uDATAPATH_BUS_B(busB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  task automatic extWrite(input logic [3:0] a, input logic [31:0] d);
    exV = 1; exA = a; exD = d;
    tick;
    exV = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic wb, input logic fl, input logic [31:0] exp);
    iv = 1; alu = op; aA = a; aB = b; aC = c; wbe = wb; fle = fl;
    sb.push_back(exp);
    tick;
    iv = 0;
  endtask

  task automatic readReg(input logic [3:0] r, input logic [31:0] exp);
    issue(ALU_PASSA, r, 4'd0, 4'd0, 1'b0, 1'b0, exp);
  endtask

  task automatic flagChk(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, {28'd0, ov, cy, ng, zr}, {28'd0, exp});
  endtask

  // scoreboard: every result strobe consumes the oldest expected value
  always @(negedge clk)
    if (rv) begin
      if (sb.size() != 0) chk("result", dout, sb.pop_front());
      else chk("spurious_valid", {31'd0, rv}, 32'd0);
    end

  initial begin
    idle(2);
    rstN = 1;
    @(negedge clk);
    chk("rst_data", dout, 0);
    chk("rst_valid", {31'd0, rv}, 0);
    chk("rst_flags", {28'd0, ov, cy, ng, zr}, 32'hF);
    chk("rst_busA", busA, 0);
    chk("rst_busB", busB, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_extready", {31'd0, exReady}, 1);
    // basic add and latency
    extWrite(1, 5);
    extWrite(2, 7);
    issue(ALU_ADD, 1, 2, 3, 1, 1, 12);
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, rv}, 0);
    tick;
    @(negedge clk);
    chk("lat_t2_valid", {31'd0, rv}, 1);
    chk("add_busA", busA, 5);
    chk("add_busB", busB, 7);
    chk("add_zero_out", {31'd0, zr}, 1);
    idle(1);
    readReg(3, 12);
    idle(2);
    // forwarding
    issue(ALU_ADD, 1, 2, 8, 1, 0, 12);
    issue(ALU_ADD, 8, 1, 9, 1, 0, 17);
    idle(3);
    readReg(9, 17);
    readReg(8, 12);
    idle(3);
    // logic and shift ops, back to back
    extWrite(10, 32'h80000000);
    extWrite(11, 32'h80000000);
    for (int i = 0; i < 8; i++) issue(tOp[i], tA[i], 4'd2, 4'd0, 1'b0, 1'b0, tE[i]);
    idle(3);
    // flags: outputs ordered {overflow, carry, negative, zero}, active-low
    issue(ALU_SUB, 10, 11, 0, 0, 1, 0);
    idle(1);
    flagChk("sub_eq_flags", 4'b1010);
    issue(ALU_ADD, 1, 2, 0, 0, 0, 12);
    idle(1);
    flagChk("noload_flags", 4'b1010);
    issue(ALU_ADD, 10, 11, 0, 0, 1, 0);
    idle(1);
    flagChk("add_ovf_flags", 4'b0010);
    issue(ALU_SUB, 1, 2, 0, 0, 1, 32'hFFFFFFFE);
    idle(1);
    flagChk("sub_borrow_flags", 4'b1101);
    issue(4'd12, 1, 2, 0, 0, 1, 0);
    idle(1);
    flagChk("badop_flags", 4'b1101);
    idle(1);
    // stall for three cycles while the op sits in stage 1
    issue(ALU_ADD, 1, 2, 13, 1, 0, 12);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rv}, 0);
      chk("stall_ready", {31'd0, ready}, 0);
      tick;
    end
    stall = 0;
    @(negedge clk);
    chk("stall_wb_valid", {31'd0, rv}, 0);
    chk("stall_wb_extready", {31'd0, exReady}, 0);
    tick;
    @(negedge clk);
    chk("stall_result_valid", {31'd0, rv}, 1);
    chk("stall_result_data", dout, 12);
    tick;
    @(negedge clk);
    chk("stall_strobe_end", {31'd0, rv}, 0);
    readReg(13, 12);
    idle(2);
    // clear wins over a write; R0 ignores writes
    exV = 1; exA = 5; exD = 32'h55; clV = 1; clA = 5;
    tick;
    exV = 0; clV = 0;
    extWrite(0, 32'hDEAD);
    extWrite(14, 9);
    readReg(5, 0);
    readReg(0, 0);
    readReg(14, 9);
    idle(2);
    // IR-selected operands: A=1, B=2, C=15
    extWrite(6, (32'd15 << 25) | (32'd1 << 14) | 32'd2);
    @(negedge clk);
    chk("ir_load", ir, 32'h1E004002);
    sA = 1; sB = 1; sC = 1;
    issue(ALU_ADD, 0, 0, 0, 1, 0, 12);
    sA = 0; sB = 0; sC = 0;
    idle(3);
    readReg(15, 12);
    idle(3);
    // reset while an op is in stage 1
    iv = 1; alu = ALU_ADD; aA = 1; aB = 2; aC = 12; wbe = 1; fle = 1;
    tick;
    iv = 0; rstN = 0;
    tick;
    rstN = 1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, rv}, 0);
    chk("midrst_flags", {28'd0, ov, cy, ng, zr}, 32'hF);
    chk("midrst_data", dout, 0);
    readReg(12, 0);
    readReg(1, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
